// File: rtl/mic_sweep_gen_pkg.sv
// Shared encodings for the MIC sweep generator: sweep modes, sweep direction
// and default widths.
package mic_sweep_gen_pkg;

    localparam int CNT_W_DEF   = 12;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        MODE_UP    = 2'd0,
        MODE_DOWN  = 2'd1,
        MODE_TRI   = 2'd2,
        MODE_FIXED = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/mic_sweep_gen_if.sv
// Control/config inputs and stimulus outputs of the MIC sweep generator.
// The bench drives the master side; the generator sits on the slave side.
interface mic_sweep_gen_if #(
    parameter int CNT_W   = 12,
    parameter int DWELL_W = 16
);
    logic               en;
    logic               restart;
    logic [1:0]         mode;
    logic [CNT_W-1:0]   p_start;
    logic [CNT_W-1:0]   p_stop;
    logic [CNT_W-1:0]   p_step;
    logic [DWELL_W-1:0] dwell_len;
    logic               bypass_clk;

    logic               mic_out;
    logic               pulse;
    logic [CNT_W-1:0]   cur_period;
    logic               sweep_wrap;
    logic               active;
    logic               cfg_err;

    modport master (
        output en, restart, mode, p_start, p_stop, p_step, dwell_len, bypass_clk,
        input  mic_out, pulse, cur_period, sweep_wrap, active, cfg_err
    );

    modport slave (
        input  en, restart, mode, p_start, p_stop, p_step, dwell_len, bypass_clk,
        output mic_out, pulse, cur_period, sweep_wrap, active, cfg_err
    );

endinterface

// File: rtl/mic_sweep_gen_step.sv
// Combinational next-period computation: one sweep step from the current
// period, with reload/clamp at the limits and direction flip for TRI.
module mic_sweep_gen_step
    import mic_sweep_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] cur,
    input  logic [CNT_W-1:0] step,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] stop,
    input  mode_e            mode,
    input  dir_e             dir,
    output logic [CNT_W-1:0] nxt,
    output logic             wrap,
    output dir_e             dir_nxt
);

    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   diff;
    logic [CNT_W-1:0] raw;

    // One extra bit so an overflow or a borrow is visible instead of wrapping.
    assign sum  = {1'b0, cur} + {1'b0, step};
    assign diff = {1'b0, cur} - {1'b0, step};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        raw     = cur;
        wrap    = 1'b0;
        dir_nxt = dir;
        if (step != '0) begin
            case (mode)
                MODE_UP: begin
                    if (sum > {1'b0, stop}) begin
                        raw  = start;
                        wrap = 1'b1;
                    end else begin
                        raw = sum[CNT_W-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (diff[CNT_W] || (diff[CNT_W-1:0] < stop)) begin
                        raw  = start;
                        wrap = 1'b1;
                    end else begin
                        raw = diff[CNT_W-1:0];
                    end
                end
                MODE_TRI: begin
                    if (dir == DIR_UP) begin
                        if (sum > {1'b0, stop}) begin
                            raw     = stop;
                            dir_nxt = DIR_DOWN;
                            wrap    = 1'b1;
                        end else begin
                            raw = sum[CNT_W-1:0];
                        end
                    end else begin
                        if (diff[CNT_W] || (diff[CNT_W-1:0] < start)) begin
                            raw     = start;
                            dir_nxt = DIR_UP;
                            wrap    = 1'b1;
                        end else begin
                            raw = diff[CNT_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
        nxt = (raw == '0) ? CNT_W'(1) : raw;
    end

endmodule

// File: rtl/mic_sweep_gen.sv
// MIC-pin pulse-train generator with a swept period. Holds the config latch,
// phase/dwell counters, the pending-update flag and the registered outputs.
module mic_sweep_gen
    import mic_sweep_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter int               DWELL_W = DWELL_W_DEF,
    parameter logic [CNT_W-1:0] P_RST   = CNT_W'(15)
) (
    input logic            sclk,
    input logic            rst,
    mic_sweep_gen_if.slave bus
);

    mode_e              cfg_mode;
    logic [CNT_W-1:0]   cfg_start;
    logic [CNT_W-1:0]   cfg_stop;
    logic [CNT_W-1:0]   cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;

    logic               active;
    logic               pulse;
    logic               sweep_wrap;
    logic               cfg_err;
    logic [CNT_W-1:0]   cur_period;
    logic [CNT_W-1:0]   phase;
    logic [DWELL_W-1:0] dwell;
    logic               pend;
    dir_e               dir;

    mode_e              in_mode;
    logic               in_bad;
    logic               latch;
    logic               phase_wrap;
    logic               expiry;
    logic               upd;
    logic [CNT_W-1:0]   nxt;
    logic               step_wrap;
    dir_e               dir_nxt;

    assign in_mode = mode_e'(bus.mode);
    assign in_bad  = (((in_mode == MODE_UP) || (in_mode == MODE_TRI)) && (bus.p_start > bus.p_stop)) ||
                     ((in_mode == MODE_DOWN) && (bus.p_start < bus.p_stop));
    assign latch   = bus.en && (!active || bus.restart);

    // Updates land only on a phase wrap, so a pulse interval is never cut short.
    assign phase_wrap = (phase == cur_period);
    assign expiry     = (dwell == cfg_dwell);
    assign upd        = phase_wrap && (pend || expiry) && !cfg_err && (cfg_mode != MODE_FIXED);

    mic_sweep_gen_step #(.CNT_W(CNT_W)) u_step (
        .cur     (cur_period),
        .step    (cfg_step),
        .start   (cfg_start),
        .stop    (cfg_stop),
        .mode    (cfg_mode),
        .dir     (dir),
        .nxt     (nxt),
        .wrap    (step_wrap),
        .dir_nxt (dir_nxt)
    );

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            cfg_mode   <= MODE_UP;
            cfg_start  <= '0;
            cfg_stop   <= '0;
            cfg_step   <= '0;
            cfg_dwell  <= '0;
            active     <= 1'b0;
            pulse      <= 1'b0;
            sweep_wrap <= 1'b0;
            cfg_err    <= 1'b0;
            cur_period <= P_RST;
            phase      <= '0;
            dwell      <= '0;
            pend       <= 1'b0;
            dir        <= DIR_UP;
        end else if (active && !bus.en) begin
            active     <= 1'b0;
            pulse      <= 1'b0;
            sweep_wrap <= 1'b0;
            phase      <= '0;
            dwell      <= '0;
            pend       <= 1'b0;
        end else if (latch) begin
            cfg_mode   <= in_mode;
            cfg_start  <= bus.p_start;
            cfg_stop   <= bus.p_stop;
            cfg_step   <= bus.p_step;
            cfg_dwell  <= bus.dwell_len;
            cfg_err    <= in_bad;
            cur_period <= (bus.p_start == '0) ? CNT_W'(1) : bus.p_start;
            active     <= 1'b1;
            pulse      <= 1'b0;
            sweep_wrap <= 1'b0;
            phase      <= '0;
            dwell      <= '0;
            pend       <= 1'b0;
            dir        <= (in_mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
        end else if (active) begin
            sweep_wrap <= 1'b0;
            if (phase_wrap) begin
                phase <= '0;
                pulse <= 1'b1;
            end else begin
                phase <= phase + 1'b1;
                pulse <= 1'b0;
            end
            dwell <= expiry ? '0 : dwell + 1'b1;
            // Expiries arriving while an update is already pending collapse into it.
            if (upd) begin
                cur_period <= nxt;
                dir        <= dir_nxt;
                sweep_wrap <= step_wrap;
                pend       <= 1'b0;
            end else if (expiry) begin
                pend <= 1'b1;
            end
        end
    end

    assign bus.mic_out    = active ? pulse : bus.bypass_clk;
    assign bus.pulse      = pulse;
    assign bus.cur_period = cur_period;
    assign bus.sweep_wrap = sweep_wrap;
    assign bus.active     = active;
    assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_mic_sweep_gen.sv
// Bench for mic_sweep_gen: table-driven sweep scenarios, hand-written corner
// sequences and random stimulus, all against an event-time reference model.
module tb_mic_sweep_gen;
    import mic_sweep_gen_pkg::*;

    localparam int CW = CNT_W_DEF;
    localparam int DW = DWELL_W_DEF;

    logic sclk = 1'b0;
    logic rst  = 1'b0;

    mic_sweep_gen_if #(.CNT_W(CW), .DWELL_W(DW)) bus ();

    mic_sweep_gen #(.CNT_W(CW), .DWELL_W(DW), .P_RST(12'h00F)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic mic, input logic err, input logic act,
                                         input logic wr, input logic pul, input logic [11:0] per);
        return {15'b0, mic, err, act, wr, pul, per};
    endfunction

    // Reference model: tracks the absolute edge numbers of the next pulse and
    // the next dwell expiry instead of counters.
    longint edge_no, next_pulse, next_exp;
    bit     m_active, m_pulse, m_wrap, m_err, m_up, m_pend;
    int     m_period, m_mode, m_start, m_stop, m_step, m_dwell;

    task automatic model_reset();
        m_active = 0; m_pulse = 0; m_wrap = 0; m_err = 0; m_up = 1; m_pend = 0;
        m_period = 15;
    endtask

    task automatic model_next();
        int s;
        if (m_step == 0) return;
        if (m_mode == 0) begin
            s = m_period + m_step;
            if (s > m_stop) begin m_period = m_start; m_wrap = 1; end else m_period = s;
        end else if (m_mode == 1) begin
            s = m_period - m_step;
            if (s < m_stop) begin m_period = m_start; m_wrap = 1; end else m_period = s;
        end else if (m_up) begin
            s = m_period + m_step;
            if (s > m_stop) begin m_period = m_stop; m_up = 0; m_wrap = 1; end else m_period = s;
        end else begin
            s = m_period - m_step;
            if (s < m_start) begin m_period = m_start; m_up = 1; m_wrap = 1; end else m_period = s;
        end
        if (m_period < 1) m_period = 1;
    endtask

    task automatic model_step();
        bit ex;
        edge_no++;
        m_pulse = 0;
        m_wrap  = 0;
        if (m_active && !bus.en) begin
            m_active = 0;
            m_pend   = 0;
        end else if (bus.en && (!m_active || bus.restart)) begin
            m_mode   = int'(bus.mode);
            m_start  = int'(bus.p_start);
            m_stop   = int'(bus.p_stop);
            m_step   = int'(bus.p_step);
            m_dwell  = int'(bus.dwell_len);
            m_err    = ((m_mode == 0 || m_mode == 2) && m_start > m_stop) || (m_mode == 1 && m_start < m_stop);
            m_period = (m_start < 1) ? 1 : m_start;
            m_up     = (m_mode != 1);
            m_pend   = 0;
            m_active = 1;
            next_pulse = edge_no + m_period + 1;
            next_exp   = edge_no + m_dwell + 1;
        end else if (m_active) begin
            ex = (edge_no == next_exp);
            if (ex) next_exp += m_dwell + 1;
            if (edge_no == next_pulse) begin
                m_pulse = 1;
                if (!m_err && m_mode != 3 && (m_pend || ex)) begin
                    model_next();
                    m_pend = 0;
                end else if (ex) begin
                    m_pend = 1;
                end
                next_pulse = edge_no + m_period + 1;
            end else if (ex) begin
                m_pend = 1;
            end
        end
    endtask

    // One clock: advance the model alongside the DUT, compare all outputs, then
    // wiggle the bypass clock for the next cycle.
    task automatic tick();
        @(posedge sclk);
        if (!rst) model_reset(); else model_step();
        #1;
        check($sformatf("cycle@%0d", edge_no),
              pack(bus.mic_out, bus.cfg_err, bus.active, bus.sweep_wrap, bus.pulse, bus.cur_period),
              pack(m_active ? m_pulse : bus.bypass_clk, m_err, m_active, m_wrap, m_pulse, 12'(m_period)));
        bus.bypass_clk = 1'($urandom_range(0, 1));
    endtask

    task automatic set_cfg(input int mode, input int start, input int stop, input int step, input int dw);
        bus.mode      = 2'(mode);
        bus.p_start   = 12'(start);
        bus.p_stop    = 12'(stop);
        bus.p_step    = 12'(step);
        bus.dwell_len = 16'(dw);
    endtask

    task automatic rand_cfg();
        set_cfg($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 40),
                $urandom_range(0, 6), $urandom_range(0, 30));
    endtask

    typedef struct {
        int mode, start, stop, step, dwell;
        int err;
        int ivl[12];
        int wmask;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cnt, np, budget;
        int saved;

        tbl[0] = '{0, 15, 33, 2, 2, 0, '{16, 18, 20, 22, 24, 26, 28, 30, 32, 34, 16, 18}, 'h200};
        tbl[1] = '{1, 33, 15, 4, 2, 0, '{34, 30, 26, 22, 18, 34, 30, 26, 22, 18, 34, 30}, 'h210};
        tbl[2] = '{2, 4, 8, 3, 0, 0, '{5, 8, 9, 6, 5, 8, 9, 6, 5, 8, 9, 6}, 'hAAA};
        tbl[3] = '{0, 0, 5, 0, 1, 0, '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2}, 'h000};
        tbl[4] = '{3, 7, 0, 3, 0, 0, '{8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8}, 'h000};
        tbl[5] = '{0, 16, 8, 1, 0, 1, '{17, 17, 17, 17, 17, 17, 17, 17, 17, 17, 17, 17}, 'h000};
        tbl[6] = '{1, 2, 0, 2, 0, 0, '{3, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3, 2}, 'hAAA};
        tbl[7] = '{2, 2, 8, 3, 0, 0, '{3, 6, 9, 9, 6, 3, 3, 6, 9, 9, 6, 3}, 'h924};

        edge_no = 0; next_pulse = 0; next_exp = 0;
        m_mode = 0; m_start = 0; m_stop = 0; m_step = 0; m_dwell = 0;
        model_reset();
        bus.en = 0; bus.restart = 0; bus.bypass_clk = 0;
        set_cfg(0, 0, 0, 0, 0);

        // Reset state, then release away from the clock edge.
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Table-driven sweep scenarios: pulse intervals and sweep_wrap positions.
        for (int t = 0; t < 8; t++) begin
            bus.en = 0;
            tick();
            set_cfg(tbl[t].mode, tbl[t].start, tbl[t].stop, tbl[t].step, tbl[t].dwell);
            bus.en = 1;
            tick();
            check($sformatf("t%0d active", t), 32'(bus.active), 32'd1);
            check($sformatf("t%0d first_period", t), 32'(bus.cur_period), 32'(tbl[t].ivl[0] - 1));
            check($sformatf("t%0d cfg_err", t), 32'(bus.cfg_err), 32'(tbl[t].err));
            rand_cfg();
            cnt = 0; np = 0; budget = 0;
            while (np < 12 && budget < 2000) begin
                tick();
                budget++;
                cnt++;
                if (bus.pulse) begin
                    check($sformatf("t%0d interval%0d", t, np), 32'(cnt), 32'(tbl[t].ivl[np]));
                    check($sformatf("t%0d wrap%0d", t, np), 32'(bus.sweep_wrap), 32'((tbl[t].wmask >> np) & 1));
                    np++;
                    cnt = 0;
                end else if (bus.sweep_wrap) begin
                    check($sformatf("t%0d stray_wrap", t), 32'(bus.sweep_wrap), 32'd0);
                end
            end
            if (np < 12) check($sformatf("t%0d pulse_timeout", t), 32'(np), 32'd12);
        end

        // en dropped mid-sweep: bypass forwarded next edge, period held; re-enable latches anew.
        bus.en = 0;
        tick();
        set_cfg(0, 15, 33, 2, 2);
        bus.en = 1;
        for (int i = 0; i < 50; i++) tick();
        saved = m_period;
        bus.en = 0;
        tick();
        check("off active", 32'(bus.active), 32'd0);
        check("off period_held", 32'(bus.cur_period), 32'(saved));
        bus.bypass_clk = 1'b1; #1;
        check("off bypass_hi", 32'(bus.mic_out), 32'd1);
        bus.bypass_clk = 1'b0; #1;
        check("off bypass_lo", 32'(bus.mic_out), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("idle period_held", 32'(bus.cur_period), 32'(saved));
        set_cfg(1, 33, 15, 4, 255);
        bus.en = 1;
        tick();
        check("reen period", 32'(bus.cur_period), 32'h21);
        for (int i = 0; i < 30; i++) tick();

        // restart while active re-latches and restarts phase.
        set_cfg(2, 4, 8, 3, 63);
        bus.restart = 1;
        tick();
        bus.restart = 0;
        check("restart period", 32'(bus.cur_period), 32'd4);
        cnt = 0;
        while (!bus.pulse && cnt < 100) begin
            tick();
            cnt++;
        end
        check("restart first_pulse", 32'(cnt), 32'd5);

        // Bad config becomes FIXED at p_start; then reset lands mid-pulse.
        set_cfg(0, 16, 8, 1, 0);
        bus.restart = 1;
        tick();
        bus.restart = 0;
        check("bad cfg_err", 32'(bus.cfg_err), 32'd1);
        check("bad period", 32'(bus.cur_period), 32'd16);
        cnt = 0;
        while (!bus.pulse && cnt < 100) begin
            tick();
            cnt++;
        end
        check("bad first_pulse", 32'(cnt), 32'd17);
        #2 rst = 1'b0;
        #1;
        check("rst mid_pulse", pack(bus.mic_out, bus.cfg_err, bus.active, bus.sweep_wrap, bus.pulse, bus.cur_period),
              pack(bus.bypass_clk, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F));
        tick();
        tick();
        rst = 1'b1;

        // Random sessions with restarts, en drops and config noise.
        for (int s = 0; s < 40; s++) begin
            rand_cfg();
            bus.en = 1;
            bus.restart = 0;
            for (int c = 0; c < 300; c++) begin
                int r;
                tick();
                bus.restart = 0;
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    bus.en = 1;
                    rand_cfg();
                    bus.restart = 1;
                end else if (r < 5) begin
                    bus.en = 0;
                end else begin
                    bus.en = 1;
                    if (r < 25) rand_cfg();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
